// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// States, default operand width, the most-negative operand value and the iteration counter width.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [WIDTH_DEFAULT-1:0] INT_MIN = {1'b1, {(WIDTH_DEFAULT-1){1'b0}}};

    function automatic int cntWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/multdiv_ctrl_addsub_w.sv
// WIDTH+1-bit adder/subtractor shared by multiply accumulate and divide trial-subtract; purely combinational.
// On subtract, carryOut = 1 means a >= b (no borrow); no handshake.
module addsub_w #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           carryOut
);

    logic [WIDTH+1:0] full;

    assign full     = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{(WIDTH+1){1'b0}}, sub};
    assign sum      = full[WIDTH:0];
    assign carryOut = full[WIDTH+1];

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequential signed multiply / restoring divide, one iteration per clock; ready pulse WIDTH cycles after the start edge.
// No input handshake: the pipeline stalls on busy, and starts arriving while iterating are dropped, not queued.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int            CW   = cntWidth(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, stateNext;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] opnd;
    logic             negRes;

    logic             startAccept;
    logic [WIDTH-1:0] absA, absB;

    logic [WIDTH:0]   addA, addB, addSum;
    logic             addSub, addCout;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   hiNext;
    logic [WIDTH-1:0] loNext;

    logic [2*WIDTH-1:0] prodMag, prodSigned;
    logic [WIDTH:0]     prodTop;
    logic [WIDTH-1:0]   quotSigned;
    logic [WIDTH-1:0]   resFinal;
    logic               excFinal;

    assign startAccept = ((state == IDLE) || (state == DONE)) && (ctrl_MULT || ctrl_DIV);
    assign absA        = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign absB        = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    assign busy           = (state == MULT) || (state == DIV);
    assign data_resultRDY = (state == DONE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: begin
                if (ctrl_MULT) begin
                    stateNext = MULT;
                end else if (ctrl_DIV) begin
                    stateNext = DIV;
                end else begin
                    stateNext = IDLE;
                end
            end
            MULT, DIV: begin
                if (cnt == LAST) begin
                    stateNext = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Divide shifts the next dividend bit into the remainder before the trial subtract.
    always_comb begin
        shifted = {accHi[WIDTH-1:0], accLo[WIDTH-1]};
        addA    = accHi;
        addB    = {1'b0, opnd};
        addSub  = 1'b0;
        if (state == DIV) begin
            addA   = shifted;
            addSub = 1'b1;
        end
    end

    addsub_w #(.WIDTH(WIDTH)) uAddSub (
        .a        (addA),
        .b        (addB),
        .sub      (addSub),
        .sum      (addSum),
        .carryOut (addCout)
    );

    always_comb begin
        hiNext = accHi;
        loNext = accLo;
        if (state == DIV) begin
            hiNext = addCout ? addSum : shifted;
            loNext = {accLo[WIDTH-2:0], addCout};
        end else begin
            hiNext = {1'b0, (accLo[0] ? addSum[WIDTH:1] : accHi[WIDTH:1])};
            loNext = {(accLo[0] ? addSum[0] : accHi[0]), accLo[WIDTH-1:1]};
        end
    end

    // Sign fix and exception on the final iteration's values, registered at DONE entry.
    always_comb begin
        prodMag    = {hiNext[WIDTH-1:0], loNext};
        prodSigned = negRes ? -prodMag : prodMag;
        prodTop    = prodSigned[2*WIDTH-1:WIDTH-1];
        quotSigned = negRes ? -loNext : loNext;
        resFinal   = prodSigned[WIDTH-1:0];
        excFinal   = !((&prodTop) || (prodTop == '0));
        if (state == DIV) begin
            if (opnd == '0) begin
                resFinal = '0;
                excFinal = 1'b1;
            end else begin
                resFinal = quotSigned;
                excFinal = loNext[WIDTH-1] & ~negRes;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt            <= '0;
            accHi          <= '0;
            accLo          <= '0;
            opnd           <= '0;
            negRes         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (startAccept) begin
            cnt    <= '0;
            accHi  <= '0;
            negRes <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            if (ctrl_MULT) begin
                accLo <= absB;
                opnd  <= absA;
            end else begin
                accLo <= absA;
                opnd  <= absB;
            end
        end else if (busy) begin
            cnt   <= cnt + 1'b1;
            accHi <= hiNext;
            accLo <= loNext;
            if (cnt == LAST) begin
                data_result    <= resFinal;
                data_exception <= excFinal;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: directed cases plus random operands against a wide-integer arithmetic reference.
// Ready latency, one-shot ready, start arbitration, reset abort and back-to-back issue are exercised.
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    localparam int W = WIDTH_DEFAULT;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         ctrl_MULT = 1'b0;
    logic         ctrl_DIV = 1'b0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        bit           isDiv;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         e;
    } case_t;

    multdiv_ctrl #(.WIDTH(W)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Reference: exact signed arithmetic in 64 bits, then range-check against W bits.
    function automatic void refModel(input bit isDiv, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output logic e);
        longint sa, sb, v;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (isDiv && sb == 0) begin
            r = '0;
            e = 1'b1;
        end else begin
            v = isDiv ? (sa / sb) : (sa * sb);
            r = v[W-1:0];
            e = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        end
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return INT_MIN;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 3));
            3:       return -32'($urandom_range(1, 300));
            default: return $urandom;
        endcase
    endfunction

    // Drive a one-cycle start; returns #1 after the accepting edge with operands scrambled.
    task automatic startOp(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic waitRdy(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        nTests++; if (data_result !== '0) begin nFail++; $display("FAIL reset result: got %h want 0", data_result); end
        nTests++; if (data_exception !== 1'b0) begin nFail++; $display("FAIL reset exc: got %b want 0", data_exception); end
        nTests++; if (data_resultRDY !== 1'b0) begin nFail++; $display("FAIL reset rdy: got %b want 0", data_resultRDY); end
        nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset busy: got %b want 0", busy); end
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        nTests++; if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            nFail++; $display("FAIL idle after reset: busy %b rdy %b want 0 0", busy, data_resultRDY);
        end
    endtask

    task automatic test_directed();
        case_t cs[6];
        int    lat;
        logic [W-1:0] held;
        cs[0] = '{1'b0, 32'd7,         -32'd3,       32'hFFFF_FFEB, 1'b0};
        cs[1] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        cs[2] = '{1'b0, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0};
        cs[3] = '{1'b1, -32'd7,        32'd2,        32'hFFFF_FFFD, 1'b0};
        cs[4] = '{1'b1, 32'd100,       32'd0,        32'h0000_0000, 1'b1};
        cs[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        foreach (cs[i]) begin
            startOp(!cs[i].isDiv, cs[i].isDiv, cs[i].a, cs[i].b);
            nTests++; if (busy !== 1'b1) begin nFail++; $display("FAIL dir%0d busy after start: got %b want 1", i, busy); end
            waitRdy(40, lat);
            nTests++; if (lat != 32) begin nFail++; $display("FAIL dir%0d latency: got %0d want 32", i, lat); end
            nTests++; if (data_result !== cs[i].r) begin nFail++; $display("FAIL dir%0d result: got %h want %h", i, data_result, cs[i].r); end
            nTests++; if (data_exception !== cs[i].e) begin nFail++; $display("FAIL dir%0d exc: got %b want %b", i, data_exception, cs[i].e); end
            nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL dir%0d busy in done: got %b want 0", i, busy); end
            held = data_result;
            @(posedge clock);
            #1;
            nTests++; if (data_resultRDY !== 1'b0) begin nFail++; $display("FAIL dir%0d rdy width: got %b want 0", i, data_resultRDY); end
            nTests++; if (data_result !== cs[i].r) begin nFail++; $display("FAIL dir%0d result hold: got %h want %h", i, data_result, held); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, r;
        logic         e;
        bit           d;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            d = 1'($urandom_range(0, 1));
            a = pickOperand();
            b = pickOperand();
            refModel(d, a, b, r, e);
            startOp(!d, d, a, b);
            waitRdy(40, lat);
            nTests++; if (lat != 32) begin nFail++; $display("FAIL rnd%0d latency: got %0d want 32", i, lat); end
            nTests++; if (data_result !== r) begin
                nFail++; $display("FAIL rnd%0d %s %h,%h result: got %h want %h", i, d ? "div" : "mul", a, b, data_result, r);
            end
            nTests++; if (data_exception !== e) begin
                nFail++; $display("FAIL rnd%0d %s %h,%h exc: got %b want %b", i, d ? "div" : "mul", a, b, data_exception, e);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_arbitration();
        int lat;
        int extra;
        startOp(1'b1, 1'b0, 32'd1234, -32'd56);
        repeat (4) @(posedge clock);
        #1;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        waitRdy(40, lat);
        nTests++; if (lat != 27) begin nFail++; $display("FAIL arb ignored-div latency: got %0d want 27", lat); end
        nTests++; if (data_result !== -32'd69104) begin nFail++; $display("FAIL arb mul result: got %h want %h", data_result, -32'd69104); end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) extra++;
        end
        nTests++; if (extra != 0) begin nFail++; $display("FAIL arb extra rdy: got %0d want 0", extra); end

        startOp(1'b1, 1'b1, 32'd6, 32'd3);
        waitRdy(40, lat);
        nTests++; if (lat != 32) begin nFail++; $display("FAIL arb both latency: got %0d want 32", lat); end
        nTests++; if (data_result !== 32'd18) begin nFail++; $display("FAIL arb both result: got %0d want 18", data_result); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        startOp(1'b0, 1'b1, 32'd1000, 32'd7);
        repeat (10) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        nTests++; if (data_result !== '0) begin nFail++; $display("FAIL midreset result: got %h want 0", data_result); end
        nTests++; if (busy !== 1'b0 || data_resultRDY !== 1'b0 || data_exception !== 1'b0) begin
            nFail++; $display("FAIL midreset flags: busy %b rdy %b exc %b want 0 0 0", busy, data_resultRDY, data_exception);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen++;
        end
        nTests++; if (seen != 0) begin nFail++; $display("FAIL midreset aborted rdy: got %0d want 0", seen); end
        startOp(1'b1, 1'b0, 32'd20, 32'd4);
        waitRdy(40, lat);
        nTests++; if (lat != 32) begin nFail++; $display("FAIL postreset latency: got %0d want 32", lat); end
        nTests++; if (data_result !== 32'd80) begin nFail++; $display("FAIL postreset result: got %0d want 80", data_result); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat, lat2;
        bit holdBad;
        startOp(1'b1, 1'b0, 32'd5, 32'd5);
        waitRdy(40, lat);
        nTests++; if (lat != 32 || data_result !== 32'd25) begin
            nFail++; $display("FAIL b2b first: latency %0d result %0d want 32 25", lat, data_result);
        end
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        nTests++; if (busy !== 1'b1) begin nFail++; $display("FAIL b2b accept in done: busy %b want 1", busy); end
        holdBad = 1'b0;
        lat2    = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat2 = k + 1;
                break;
            end
            if (data_result !== 32'd25) holdBad = 1'b1;
        end
        nTests++; if (lat2 != 33) begin nFail++; $display("FAIL b2b gap: got %0d want 33", lat2); end
        nTests++; if (holdBad) begin nFail++; $display("FAIL b2b hold: result changed before second rdy, want 25"); end
        nTests++; if (data_result !== 32'd3 || data_exception !== 1'b0) begin
            nFail++; $display("FAIL b2b second: result %0d exc %b want 3 0", data_result, data_exception);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_arbitration();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequential signed multiply/divide unit for the processor's execute stage. It accepts a one-cycle start pulse, latches both 32-bit operands and runs one shift-add (multiply) or restoring-division (divide) iteration per clock. It raises a single-cycle ready pulse with the result and an exception flag. The pipeline stalls on `busy` while the unit runs.

## Interface
- `WIDTH`, default 32: operand and result width; iteration count equals `WIDTH`.

Ports, as name / direction / width / meaning:
- `clock` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ctrl_MULT` in 1: start-multiply pulse.
- `ctrl_DIV` in 1: start-divide pulse.
- `data_operandA` in WIDTH: multiplicand / dividend, two's complement.
- `data_operandB` in WIDTH: multiplier / divisor, two's complement.
- `data_result` out WIDTH: product low word / quotient.
- `data_exception` out 1: overflow or divide-by-zero.
- `data_resultRDY` out 1: one-cycle result-valid pulse.
- `busy` out 1: high while an operation iterates.

## Operation
- States:
  - IDLE
  - MULT
  - DIV
  - DONE
- Start acceptance:
  - A start is accepted in IDLE or DONE only.
  - At the accepting edge, the operands, their signs and op type are latched, and the iteration counter clears to 0.
  - `ctrl_MULT` and `ctrl_DIV` high together: the multiply wins and the divide is dropped.
  - Starts in MULT or DIV are ignored. They are not queued.
- MULT:
  - Runs on magnitudes |A| and |B|, with a 2·WIDTH-bit partial product.
  - One shift-add per edge.
- DIV:
  - Restoring division on magnitudes, with a WIDTH+1-bit remainder.
  - One shift-subtract-restore per edge.
- Counter behaviour: the counter increments each iterating edge. The edge with counter = WIDTH-1 does the last iteration and moves to DONE.
- Sign fix: negate the result if the operand signs differ. It is applied combinationally on the last iteration and registered into `data_result` at the DONE-entry edge.
- Multiply exception:
  - `data_exception` = 1 when the true signed 2·WIDTH-bit product lies outside the signed WIDTH-bit range. Equivalently, the upper WIDTH+1 product bits are not all equal.
  - `data_result` is always the low WIDTH bits of the product.
- Divide behaviour:
  - The quotient truncates toward zero. The remainder is discarded.
  - Divisor 0: `data_result` = 0, `data_exception` = 1, same latency as normal.
  - Dividend INT_MIN with divisor -1: `data_result` = INT_MIN (0x80000000), `data_exception` = 1.
- DONE:
  - `data_resultRDY` = 1 for exactly this one state-cycle.
  - Goes to IDLE next edge, or straight to MULT/DIV if a start is present.
- Result hold: `data_result` and `data_exception` hold their values until the next DONE-entry edge. Operand changes after the start edge have no effect.
- Reset mid-operation:
  - The state returns to IDLE immediately. The counter and all outputs go to 0.
  - No ready pulse is produced for the aborted operation.

## Timing
- Reset values: `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0, state IDLE.
- Start edge E0.
- E1…E(WIDTH) are the iterating edges. `busy` = 1 from just after E0 until E(WIDTH).
- `data_resultRDY` is high in the cycle between E(WIDTH) and E(WIDTH+1). For WIDTH = 32, that is 32 cycles after the start edge, for every op including divide-by-zero.
- `data_result` and `data_exception` are valid from E(WIDTH) onward.
- `busy` and `data_resultRDY` are decoded from registered state only, so they are glitch-free. `busy` is 0 in IDLE and DONE.
- Back-to-back: a start in the DONE cycle is accepted at E(WIDTH+1). The next ready pulse follows WIDTH cycles later. Minimum issue interval is WIDTH+1 cycles.

## Structure
- Package `multdiv_pkg`:
  - state enum {IDLE, MULT, DIV, DONE}
  - `WIDTH_DEFAULT` = 32
  - `INT_MIN` constant
  - counter width = clog2(WIDTH)
- Sub-module `addsub_w`: a WIDTH+1-bit adder/subtractor with a `sub` control input and carry-out. It is shared by the multiply accumulate and divide trial-subtract steps, since only one op runs at a time.
- Everything else (FSM, counter, shift registers, sign-fix negation) lives in `multdiv_ctrl`.

## Test plan
- Signed multiply: 7 × -3 → `data_result` 0xFFFFFFEB, exc 0, RDY high exactly 32 cycles after the start edge and for one cycle only.
- Multiply overflow: 0x00010000 × 0x00010000 → result 0x00000000, exc 1. 0x80000000 × 1 → 0x80000000, exc 0.
- Divide cases:
  - -7 ÷ 2 → 0xFFFFFFFD, exc 0.
  - 100 ÷ 0 → 0, exc 1, RDY at cycle 32.
  - 0x80000000 ÷ -1 → 0x80000000, exc 1.
- Start arbitration:
  - `ctrl_DIV` pulsed at cycle 5 of a multiply is ignored. The multiply result is correct and only one RDY appears.
  - `ctrl_MULT` and `ctrl_DIV` together with A=6, B=3 → result 18.
- Reset: `resetn` low at cycle 10 of a divide → all outputs 0 asynchronously and no RDY. After release, 20 × 4 completes → 80 at cycle 32.
- Back-to-back: 5 × 5 started, then a second start 9 ÷ 3 in the DONE cycle → RDY with 25, then RDY with 3 exactly 33 cycles later. `data_result` holds 25 in between.
